// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end for a shared external ALU.
// Latches the granted operation, waits out mul/div latency and holds the result until taken.
module alu_arb_ctrl #(
    parameter int unsigned MULDIV_WAIT = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [3:0]  i_req0_sel,
    input  logic [31:0] i_req0_a,
    input  logic [31:0] i_req0_b,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [3:0]  i_req1_sel,
    input  logic [31:0] i_req1_a,
    input  logic [31:0] i_req1_b,
    output logic [1:0]  o_resp_valid,
    input  logic [1:0]  i_resp_ready,
    output logic [31:0] o_resp_data,
    output logic [4:0]  o_resp_flags,
    output logic        o_resp_err,
    output logic [3:0]  o_alu_sel,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    input  logic [31:0] i_alu_out,
    input  logic [4:0]  i_alu_flags,
    output logic        o_busy
);

    localparam logic [3:0] LP_WAIT    = 4'(MULDIV_WAIT);
    localparam logic [3:0] LP_SEL_MUL = 4'b0010;
    localparam logic [3:0] LP_SEL_DIV = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last;
    logic        r_id;
    logic [3:0]  r_sel;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_cnt;
    logic [31:0] r_resp_data;
    logic [4:0]  r_resp_flags;
    logic        r_resp_err;

    logic        w_gnt;
    logic        w_req0_ready;
    logic        w_req1_ready;
    logic        w_accept;
    logic [3:0]  w_sel;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_div_zero;
    logic        w_muldiv;

    // Requester mux feeds both the operand latches and the divide-by-zero shortcut.
    always_comb begin
        w_sel      = w_gnt ? i_req1_sel : i_req0_sel;
        w_a        = w_gnt ? i_req1_a   : i_req0_a;
        w_b        = w_gnt ? i_req1_b   : i_req0_b;
        w_div_zero = (w_sel == LP_SEL_DIV) && (w_b == 32'd0);
        w_muldiv   = (w_sel == LP_SEL_MUL) || (w_sel == LP_SEL_DIV);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt        = 1'b0;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req0_valid && i_req1_valid) begin
                    w_gnt = ~r_last;
                end else begin
                    w_gnt = i_req1_valid;
                end
                w_req0_ready = i_rst_n && i_req0_valid && !w_gnt;
                w_req1_ready = i_rst_n && i_req1_valid && w_gnt;
                w_accept     = w_req0_ready || w_req1_ready;
                if (w_accept) begin
                    w_state_nxt = w_div_zero ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_resp_ready[r_id]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_last       <= 1'b1;
            r_id         <= 1'b0;
            r_sel        <= 4'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_cnt        <= 4'd0;
            r_resp_data  <= 32'd0;
            r_resp_flags <= 5'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last <= w_gnt;
                r_id   <= w_gnt;
                r_sel  <= w_sel;
                r_a    <= w_a;
                r_b    <= w_b;
                if (w_div_zero) begin
                    r_cnt        <= 4'd0;
                    r_resp_data  <= 32'hFFFF_FFFF;
                    r_resp_flags <= 5'd0;
                    r_resp_err   <= 1'b1;
                end else begin
                    r_cnt <= w_muldiv ? LP_WAIT : 4'd0;
                end
            end
            if (r_state == ST_EXEC) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_resp_data  <= i_alu_out;
                    r_resp_flags <= i_alu_flags;
                    r_resp_err   <= 1'b0;
                end
            end
        end
    end

    assign o_req0_ready = w_req0_ready;
    assign o_req1_ready = w_req1_ready;
    assign o_resp_valid = (r_state == ST_RESP) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
    assign o_resp_data  = r_resp_data;
    assign o_resp_flags = r_resp_flags;
    assign o_resp_err   = r_resp_err;
    assign o_alu_sel    = r_sel;
    assign o_alu_a      = r_a;
    assign o_alu_b      = r_b;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: doc/alu_arb_ctrl.md
ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 Parameter: MULDIV_WAIT, default 3, extra EXEC cycles for ALU_SEL 4'b0010 (multiply) and 4'b0011 (divide); legal 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 REQ0_VALID / REQ1_VALID  input  1  requester n presents an operation.
REQ-005 REQ0_READY / REQ1_READY  output  1  operation of requester n accepted this cycle.
REQ-006 REQ0_SEL / REQ1_SEL  input  4  ALU opcode from requester n.
REQ-007 REQ0_A, REQ0_B / REQ1_A, REQ1_B  input  32  operands from requester n.
REQ-008 RESP_VALID  output  2  one-hot; bit n = result for requester n pending.
REQ-009 RESP_READY  input  2  bit n = requester n takes result.
REQ-010 RESP_DATA  output  32  captured result.
REQ-011 RESP_FLAGS  output  5  captured {carry, zero, negative, overflow, underflow}.
REQ-012 RESP_ERR  output  1  divide-by-zero indication.
REQ-013 ALU_SEL  output  4; ALU_A, ALU_B  output  32  operation driven to the shared ALU.
REQ-014 ALU_OUT  input  32; ALU_FLAGS  input  5  ALU result and flags, same order as RESP_FLAGS.
REQ-015 BUSY  output  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, EXEC, RESP; encoding free.
REQ-017 IDLE: REQn_READY combinationally high only for the granted requester when its REQn_VALID is high; at most one READY high per cycle; READY low in EXEC and RESP.
REQ-018 Grant: one valid -> that one; both valid -> requester not granted last (round-robin); last-grant pointer updates only on accept.
REQ-019 Accept (VALID&READY at edge): latch SEL/A/B and requester id; ALU_SEL/ALU_A/ALU_B driven from latches until next accept.
REQ-020 Accept with SEL=4'b0011 and B=0: skip EXEC, go RESP with RESP_DATA=32'hFFFFFFFF, RESP_FLAGS=0, RESP_ERR=1.
REQ-021 Otherwise accept -> EXEC; wait counter loaded with MULDIV_WAIT for SEL 4'b0010/4'b0011, else 0.
REQ-022 EXEC: counter nonzero -> decrement, stay; counter zero -> capture ALU_OUT into RESP_DATA, ALU_FLAGS into RESP_FLAGS, RESP_ERR=0, go RESP.
REQ-023 Latency: RESP_VALID first high 2 cycles after accept edge for single-cycle ops, 2+MULDIV_WAIT for mul/div, 1 cycle for divide-by-zero.
REQ-024 RESP: RESP_VALID bit of latched requester high, other bit low; DATA/FLAGS/ERR stable until handshake.
REQ-025 RESP handshake (RESP_VALID[n]&RESP_READY[n]) -> IDLE; RESP_READY of non-addressed bit ignored.
REQ-026 A new request is accepted no earlier than the cycle after the RESP handshake (no overlap); throughput max one op per 3 cycles.
REQ-027 Requester VALID/SEL/A/B held stable until READY; VALID dropped before READY is legal and causes no accept.
REQ-028 Opcodes 4'b0000-4'b1111 all forwarded unchanged; controller does not interpret results.

Reset
REQ-029 rst_n low at a rising edge: state IDLE, last-grant pointer = requester 1 (requester 0 wins first tie), counter 0.
REQ-030 Reset values: REQn_READY 0 while rst_n low, RESP_VALID 2'b00, RESP_DATA 0, RESP_FLAGS 0, RESP_ERR 0, ALU_SEL 0, ALU_A 0, ALU_B 0, BUSY 0.
REQ-031 Reset in EXEC or RESP aborts the operation; pending result discarded, no RESP_VALID after reset release until a new accept.

Verification
REQ-032 REQ0 SEL=0000 A=5 B=7, RESP_READY=11 -> accept cycle 0, RESP_VALID=01 cycle 2, RESP_DATA=12, zero=0.
REQ-033 Both VALID every cycle, REQ0 SEL=1000, REQ1 SEL=1001 -> grants alternate 0,1,0,1 starting with REQ0; each RESP_VALID bit matches grant.
REQ-034 REQ1 SEL=0010 A=6 B=7, MULDIV_WAIT=3 -> RESP_VALID=10 at 5 cycles after accept, RESP_DATA=42.
REQ-035 REQ0 SEL=0011 A=9 B=0 -> RESP_VALID=01 one cycle after accept, RESP_DATA=FFFFFFFF, RESP_ERR=1; ALU result not captured.
REQ-036 RESP_READY held 00 for 10 cycles -> RESP_VALID, DATA, FLAGS stable, REQ READY low, BUSY=1 throughout.
REQ-037 rst_n low for one edge during EXEC of a mul -> next cycle IDLE, all outputs at REQ-030 values, no response emitted.
